// File: rtl/component_result_buffer.sv
// Credit-checked wrapper around a fixed-latency, non-stallable pipeline.
// Valid tokens travel beside the pipeline data and land in a result FIFO that the consumer can stall.
module component_result_buffer #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         issue_en,
  input  logic [WIDTH-1:0]             dly_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [LATENCY-1:0] vtok;
  logic               arrive;
  logic               pop;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      occ;
  logic [WIDTH-1:0]   mem [DEPTH];

  // Credit is reserved at issue, so the FIFO can never overflow on arrival.
  assign in_ready  = (outstanding < CW'(DEPTH)) & ~rst;
  assign issue_en  = in_valid & in_ready;
  assign arrive    = vtok[LATENCY-1];
  assign out_valid = (occ != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vtok <= '0;
    end else begin
      vtok[0] <= issue_en;
      for (int i = 1; i < LATENCY; i++) begin
        vtok[i] <= vtok[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (arrive) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      occ <= occ + CW'(arrive) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (arrive) begin
      mem[wr_ptr] <= dly_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue_en) - CW'(pop);
    end
  end

endmodule
